wfg_wb_intercon: RTL and testbench
==================================

// Module: wfg_wb_intercon
// PURPOSE
// - Parametrised Wishbone classic 1-master/N-slave interconnect for the waveform generator; replaces the hard-wired page decode.
// - Sits between the Caravel user Wishbone port and the wfg_* peripherals.
// - Adds a registered slave select, stray-ack filtering, an unmapped-address error response and a bus timeout watchdog.
// PARAMETERS
// - BUSW      32           data and address width
// - NSLAVES   6            number of slave ports, 1..15
// - BASE_NIB  4'h3         required value of adr[BUSW-1:BUSW-4]
// - ADRW      4            slave-local address width forwarded (adr[ADRW-1:0])
// - TIMEOUT   255          cycles waiting for a slave ack before error; 0 = watchdog disabled
// - ERR_DATA  32'hDEADBEEF read data returned on an error response
// PORTS
// - io_wbs_clk     in   1            system clock
// - io_wbs_rst     in   1            synchronous reset, active-high
// - io_wbs_adr     in   BUSW         master address
// - io_wbs_datwr   in   BUSW         master write data
// - io_wbs_we      in   1            master write enable
// - io_wbs_stb     in   1            master strobe
// - io_wbs_cyc     in   1            master cycle
// - io_wbs_datrd   out  BUSW         read data to master
// - io_wbs_ack     out  1            ack to master; also asserted on error terminations
// - io_wbs_err     out  1            1-cycle pulse, coincident with ack, marking an error termination
// - s_stb_o        out  NSLAVES      per-slave strobe
// - s_cyc_o        out  NSLAVES      per-slave cycle
// - s_we_o         out  1            shared write enable
// - s_adr_o        out  ADRW         shared slave-local address
// - s_dat_o        out  BUSW         shared write data
// - s_ack_i        in   NSLAVES      per-slave ack
// - s_dat_i        in   NSLAVES*BUSW flattened slave read data; slave k at [k*BUSW +: BUSW]
// - err_clr_i      in   1            clears the sticky status
// - err_sticky_o   out  1            sticky: any error since the last clear
// - err_cause_o    out  2            last cause: 00 none, 01 unmapped, 10 timeout, 11 stray ack
// BEHAVIOUR
// - Decode: hit when adr[BUSW-1:BUSW-4]==BASE_NIB and page p = adr[BUSW-5:ADRW] satisfies 1<=p<=NSLAVES.
//   - Slave index is p-1. Page 0 and all other pages are unmapped.
// - FSM states: IDLE, ACTIVE, ERR. Reset forces IDLE.
//   - IDLE: on cyc&&stb, a hit latches idx and goes to ACTIVE; a miss goes to ERR.
//   - ACTIVE: s_stb_o[idx]=stb, s_cyc_o[idx]=cyc, all other bits 0.
//     - io_wbs_ack = s_ack_i[idx], combinational, io_wbs_datrd = s_dat_i[idx]; on ack go to IDLE.
//   - ERR: one cycle; ack=1, err=1, datrd=ERR_DATA; then IDLE. Not entered if cyc dropped.
// - Latency: the slave sees stb 1 cycle after the master; the master sees ack in the slave's ack cycle.
//   - Unmapped address: ack+err 1 cycle after the request.
// - Watchdog: counter cleared on entry to ACTIVE, incremented each ACTIVE cycle without ack.
//   - Count reaching TIMEOUT goes to ERR with cause 10; the slave strobe drops that cycle.
// - Abort: cyc low in ACTIVE returns to IDLE next cycle, with no ack and no error.
// - Stray ack: any s_ack_i bit other than idx, or any s_ack_i in IDLE/ERR, is ignored.
//   - It sets sticky and cause=11; the master transaction is unaffected.
// - Simultaneous events:
//   - Ack in the same cycle the watchdog hits TIMEOUT: the ack wins, no error.
//   - Error set with err_clr_i: set wins.
// - Outputs in IDLE/ERR: s_stb_o=0, s_cyc_o=0, datrd=0 (IDLE) or ERR_DATA (ERR).
//   - s_adr_o/s_dat_o/s_we_o pass through at all times.
// - Reset values: all outputs 0, counter 0, idx 0. Reset mid-ACTIVE drops slave stb next edge with no ack.
// - Width rules: counter width $clog2(TIMEOUT+1), minimum 1. idx width $clog2(NSLAVES), minimum 1.
// STRUCTURE
// - Package wfg_wb_intercon_pkg: state enum {IDLE,ACTIVE,ERR}, err-cause enum, CAUSE_* localparams.
// - Sub-module wfg_wb_addr_dec: combinational decode; adr -> hit, idx. Parametrised on BUSW/NSLAVES/BASE_NIB/ADRW.
// - FSM, watchdog, stray detect and muxes live in this module.
// TESTING
// - Read 0x3000_0034 with slave 2 acking after 3 cycles -> s_stb_o=3'b100 pattern from cycle 1.
//   - ack at cycle 4 with slave 2 data; s_adr_o=4'h4.
// - Write 0x3000_0000 (page 0) -> ack+err at cycle 1, datrd 0xDEADBEEF, err_cause_o=01, sticky=1.
//   - Then err_clr_i -> sticky=0.
// - Read 0x3000_0010 with TIMEOUT=4 and no slave ack -> ack+err after 4 ACTIVE cycles, cause=10.
//   - s_stb_o[0] low thereafter.
// - Slave 5 acks while slave 1 is active -> cause=11, sticky=1.
//   - Slave 1's later ack completes normally with its data.
// - Master drops cyc after 2 ACTIVE cycles -> no ack, FSM IDLE, no error.
//   - Assert io_wbs_rst mid-ACTIVE -> all outputs 0 next cycle.
// - Ack arriving exactly on the TIMEOUT cycle -> normal ack, err=0, sticky unchanged.

Source files
------------

// File: rtl/wfg_wb_intercon_pkg.sv
// wfg_wb_intercon_pkg: shared state/cause types and width helper for the Wishbone interconnect
package wfg_wb_intercon_pkg;
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_STRAY    = 2'b11;
  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;
  typedef enum logic [1:0] {
    EC_NONE     = CAUSE_NONE,
    EC_UNMAPPED = CAUSE_UNMAPPED,
    EC_TIMEOUT  = CAUSE_TIMEOUT,
    EC_STRAY    = CAUSE_STRAY
  } err_cause_t;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wfg_wb_addr_dec.sv
// wfg_wb_addr_dec: page decode of a master address into slave hit and index
// adr in : master address; hit out : mapped page; idx out : slave index (page-1)
module wfg_wb_addr_dec import wfg_wb_intercon_pkg::*; #(
  parameter int BUSW = 32,
  parameter int NSLAVES = 6,
  parameter logic [3:0] BASE_NIB = 4'h3,
  parameter int ADRW = 4,
  localparam int IW = clog2_min1(NSLAVES)
) (
  input  logic [BUSW-1:0] adr,
  output logic            hit,
  output logic [IW-1:0]   idx
);
  localparam int PW = BUSW - 4 - ADRW;
  logic [PW-1:0] page;
  logic unused_low;
  assign page = adr[BUSW-5:ADRW];
  assign unused_low = ^adr[ADRW-1:0];
  assign hit = adr[BUSW-1:BUSW-4] == BASE_NIB && page != '0 && page <= PW'(NSLAVES);
  assign idx = IW'(page - PW'(1));
endmodule

// File: rtl/wfg_wb_intercon.sv
// wfg_wb_intercon: Wishbone classic 1-master/N-slave interconnect with error response and watchdog
// io_wbs_* : master side (clk, sync active-high rst, adr/datwr/we/stb/cyc in; datrd/ack/err out)
// s_*      : slave side (per-slave stb/cyc, shared we/adr/dat out; per-slave ack and flattened data in)
// err_*    : sticky error flag with clear, and last error cause
module wfg_wb_intercon import wfg_wb_intercon_pkg::*; #(
  parameter int BUSW = 32,
  parameter int NSLAVES = 6,
  parameter logic [3:0] BASE_NIB = 4'h3,
  parameter int ADRW = 4,
  parameter int TIMEOUT = 255,
  parameter logic [BUSW-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                    io_wbs_clk,
  input  logic                    io_wbs_rst,
  input  logic [BUSW-1:0]         io_wbs_adr,
  input  logic [BUSW-1:0]         io_wbs_datwr,
  input  logic                    io_wbs_we,
  input  logic                    io_wbs_stb,
  input  logic                    io_wbs_cyc,
  output logic [BUSW-1:0]         io_wbs_datrd,
  output logic                    io_wbs_ack,
  output logic                    io_wbs_err,
  output logic [NSLAVES-1:0]      s_stb_o,
  output logic [NSLAVES-1:0]      s_cyc_o,
  output logic                    s_we_o,
  output logic [ADRW-1:0]         s_adr_o,
  output logic [BUSW-1:0]         s_dat_o,
  input  logic [NSLAVES-1:0]      s_ack_i,
  input  logic [NSLAVES*BUSW-1:0] s_dat_i,
  input  logic                    err_clr_i,
  output logic                    err_sticky_o,
  output logic [1:0]              err_cause_o
);
  localparam int IW = clog2_min1(NSLAVES);
  localparam int CW = clog2_min1(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t state, nxt;
  err_cause_t cause, cause_nxt;
  logic [IW-1:0] idx, dec_idx;
  logic [CW-1:0] cnt;
  logic [NSLAVES-1:0] sel_oh;
  logic [BUSW-1:0] rdat;
  logic dec_hit, req, sel_ack, tmo, stray, sticky;
  wfg_wb_addr_dec #(.BUSW(BUSW), .NSLAVES(NSLAVES), .BASE_NIB(BASE_NIB), .ADRW(ADRW)) u_dec (
    .adr(io_wbs_adr),
    .hit(dec_hit),
    .idx(dec_idx)
  );
  assign req = io_wbs_cyc & io_wbs_stb;
  assign sel_oh = NSLAVES'(1) << idx;
  assign sel_ack = |(s_ack_i & sel_oh);
  // watchdog fires on the last ACTIVE cycle so ERR follows exactly TIMEOUT ACTIVE cycles
  assign tmo = TIMEOUT != 0 && cnt == TLAST;
  // any ack not belonging to the selected slave of a live transfer is stray
  assign stray = state == ACTIVE ? |(s_ack_i & ~sel_oh) : |s_ack_i;
  assign s_we_o = io_wbs_we;
  assign s_adr_o = io_wbs_adr[ADRW-1:0];
  assign s_dat_o = io_wbs_datwr;
  assign err_sticky_o = sticky;
  assign err_cause_o = cause;
  always_comb begin
    rdat = '0;
    for (int i = 0; i < NSLAVES; i++) if (IW'(i) == idx) rdat = s_dat_i[i*BUSW +: BUSW];
  end
  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = !req ? IDLE : dec_hit ? ACTIVE : ERR;
    else if (state == ACTIVE) nxt = !io_wbs_cyc || sel_ack ? IDLE : tmo ? ERR : ACTIVE;
    else nxt = IDLE;
  end
  always_comb begin
    cause_nxt = state == IDLE && req && !dec_hit ? EC_UNMAPPED :
                state == ACTIVE && io_wbs_cyc && !sel_ack && tmo ? EC_TIMEOUT :
                stray ? EC_STRAY : EC_NONE;
    io_wbs_ack = state == ERR || (state == ACTIVE && sel_ack);
    io_wbs_err = state == ERR;
    io_wbs_datrd = state == ERR ? ERR_DATA : state == ACTIVE ? rdat : '0;
    s_stb_o = state == ACTIVE && io_wbs_stb ? sel_oh : '0;
    s_cyc_o = state == ACTIVE && io_wbs_cyc ? sel_oh : '0;
  end
  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      sticky <= 1'b0;
      cause <= EC_NONE;
    end else begin
      state <= nxt;
      if (state == IDLE && req && dec_hit) idx <= dec_idx;
      cnt <= state == ACTIVE && !sel_ack ? cnt + 1'b1 : '0;
      sticky <= cause_nxt != EC_NONE || (sticky && !err_clr_i);
      if (cause_nxt != EC_NONE) cause <= cause_nxt;
    end
  end
endmodule

// File: tb/tb_wfg_wb_intercon.sv
// tb_wfg_wb_intercon: directed bench with a transaction-level model checked every cycle
module tb_wfg_wb_intercon;
  localparam int NS = 6;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic rst, we, stb, cyc, err_clr;
  logic [31:0] adr, datwr, datrd;
  logic ack, err, s_we, sticky;
  logic [5:0] s_stb, s_cyc, s_ack;
  logic [3:0] s_adr;
  logic [31:0] s_dat;
  logic [NS*32-1:0] s_dat_i;
  logic [1:0] cause;
  int total = 0, bad = 0;
  bit chk_en = 0;
  bit m_busy = 0, m_err = 0, m_sticky = 0;
  int m_sel = 0, m_wait = 0;
  logic [1:0] m_cause = 2'b00;
  logic [31:0] unm [4] = '{32'h3000_0000, 32'h3000_0070, 32'h4000_0010, 32'h3000_0100};

  wfg_wb_intercon #(.TIMEOUT(TMO)) dut (
    .io_wbs_clk(clk), .io_wbs_rst(rst), .io_wbs_adr(adr), .io_wbs_datwr(datwr),
    .io_wbs_we(we), .io_wbs_stb(stb), .io_wbs_cyc(cyc), .io_wbs_datrd(datrd),
    .io_wbs_ack(ack), .io_wbs_err(err), .s_stb_o(s_stb), .s_cyc_o(s_cyc),
    .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_dat), .s_ack_i(s_ack),
    .s_dat_i(s_dat_i), .err_clr_i(err_clr), .err_sticky_o(sticky), .err_cause_o(cause)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sd(input int k);
    return 32'hC0DE_0000 | (k * 32'h1111);
  endfunction

  function automatic bit hit(input logic [31:0] a, output int s);
    int p;
    p = int'((a >> 4) & 32'h00FF_FFFF);
    s = p - 1;
    return a[31:28] == 4'h3 && p >= 1 && p <= NS;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int s;
    bit h, a, tmo;
    logic [5:0] own, other;
    logic [1:0] c;
    h = hit(adr, s);
    own = m_busy ? 6'b1 << m_sel : 6'b0;
    a = m_busy && (s_ack & own) != 0;
    other = s_ack & ~own;
    if (rst) begin
      m_busy = 0; m_err = 0; m_sel = 0; m_wait = 0; m_sticky = 0; m_cause = 2'b00;
    end else begin
      tmo = m_busy && cyc && !a && m_wait + 1 == TMO;
      c = 2'b00;
      if (!m_busy && !m_err && cyc && stb && !h) c = 2'b01;
      else if (tmo) c = 2'b10;
      else if (other != 0) c = 2'b11;
      if (c != 2'b00) begin
        m_cause = c;
        m_sticky = 1;
      end else if (err_clr) m_sticky = 0;
      if (m_err) m_err = 0;
      else if (m_busy) begin
        if (!cyc || a) m_busy = 0;
        else if (tmo) begin
          m_busy = 0;
          m_err = 1;
        end else m_wait++;
      end else if (cyc && stb) begin
        if (h) begin
          m_busy = 1;
          m_sel = s;
          m_wait = 0;
        end else m_err = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      logic [5:0] sel;
      sel = m_busy ? 6'b1 << m_sel : 6'b0;
      check("cmp_ack", ack, m_err || (s_ack & sel) != 0);
      check("cmp_err", err, m_err);
      check("cmp_datrd", datrd, m_err ? 32'hDEAD_BEEF : m_busy ? sd(m_sel) : 32'h0);
      check("cmp_s_stb", s_stb, stb ? sel : 6'b0);
      check("cmp_s_cyc", s_cyc, cyc ? sel : 6'b0);
      check("cmp_s_adr", s_adr, adr[3:0]);
      check("cmp_s_dat", s_dat, datwr);
      check("cmp_s_we", s_we, we);
      check("cmp_sticky", sticky, m_sticky);
      check("cmp_cause", cause, m_cause);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic [31:0] a, input logic w);
    adr = a; we = w; cyc = 1; stb = 1;
  endtask

  task automatic idle();
    cyc = 0; stb = 0; s_ack = '0;
  endtask

  initial begin
    rst = 1; adr = '0; datwr = '0; we = 0; err_clr = 0;
    idle();
    for (int k = 0; k < NS; k++) s_dat_i[k*32 +: 32] = sd(k);
    tick();
    chk_en = 1;
    #1;
    check("rst_ack", ack, 0);
    check("rst_stb", s_stb, 0);
    check("rst_datrd", datrd, 0);
    check("rst_sticky", sticky, 0);
    check("rst_cause", cause, 0);
    tick(); rst = 0;
    // read slave 2, ack after three wait cycles (also the watchdog's last cycle)
    tick(); req(32'h3000_0034, 0); #1;
    check("t1_s_adr", s_adr, 4'h4);
    check("t1_c0_stb", s_stb, 6'b0);
    for (int k = 1; k <= 4; k++) begin
      tick(); s_ack = k == 4 ? 6'b000100 : 6'b0; #1;
      check("t1_stb", s_stb, 6'b000100);
      check("t1_ack", ack, k == 4);
    end
    check("t1_dat", datrd, 32'hC0DE_2222);
    check("t1_err", err, 0);
    tick(); idle(); #1;
    check("t1_done_ack", ack, 0);
    // unmapped addresses: page 0, page past NSLAVES, wrong base nibble, high page bits
    for (int i = 0; i < 4; i++) begin
      tick(); req(unm[i], i == 0); datwr = 32'h1234_5678; #1;
      if (i == 0) begin
        check("t2_we", s_we, 1);
        check("t2_dat", s_dat, 32'h1234_5678);
      end
      tick(); #1;
      check("t2_ack", ack, 1);
      check("t2_err", err, 1);
      check("t2_datrd", datrd, 32'hDEAD_BEEF);
      check("t2_cause", cause, 2'b01);
      check("t2_sticky", sticky, 1);
      check("t2_stb", s_stb, 0);
      tick(); idle(); err_clr = 1; #1;
      check("t2_ack_off", ack, 0);
      tick(); err_clr = 0; #1;
      check("t2_clr", sticky, 0);
    end
    // watchdog timeout on slave 0
    tick(); req(32'h3000_0010, 0);
    for (int k = 1; k <= TMO; k++) begin
      tick(); #1;
      check("t3_stb", s_stb, 6'b000001);
      check("t3_ack", ack, 0);
    end
    tick(); #1;
    check("t3_ack_err", {ack, err}, 2'b11);
    check("t3_stb_drop", s_stb, 0);
    check("t3_datrd", datrd, 32'hDEAD_BEEF);
    check("t3_cause", cause, 2'b10);
    check("t3_sticky", sticky, 1);
    tick(); idle(); err_clr = 1; #1;
    check("t3_after", s_stb, 0);
    tick(); err_clr = 0; #1;
    check("t3_clr", sticky, 0);
    // stray ack from slave 5 while slave 1 is active
    tick(); req(32'h3000_0020, 0);
    tick(); s_ack = 6'b100000; #1;
    check("t4_stb", s_stb, 6'b000010);
    check("t4_stray_ack", ack, 0);
    tick(); s_ack = 6'b0; #1;
    check("t4_cause", cause, 2'b11);
    check("t4_sticky", sticky, 1);
    tick(); s_ack = 6'b000010; #1;
    check("t4_ack", ack, 1);
    check("t4_err", err, 0);
    check("t4_dat", datrd, 32'hC0DE_1111);
    tick(); idle(); err_clr = 1;
    tick(); err_clr = 0; #1;
    check("t4_clr", sticky, 0);
    // master abort after two active cycles
    tick(); req(32'h3000_0050, 0);
    for (int k = 1; k <= 2; k++) begin
      tick(); #1;
      check("t5_stb", s_stb, 6'b010000);
    end
    tick(); idle(); #1;
    check("t5_stb_off", s_stb, 0);
    check("t5_cyc_off", s_cyc, 0);
    tick(); #1;
    check("t5_ack", ack, 0);
    check("t5_err", err, 0);
    check("t5_sticky", sticky, 0);
    // ack on the timeout cycle wins over the watchdog
    tick(); req(32'h3000_0018, 0);
    for (int k = 1; k <= TMO; k++) begin
      tick(); s_ack = k == TMO ? 6'b000001 : 6'b0; #1;
      check("t6_ack", ack, k == TMO);
    end
    check("t6_err", err, 0);
    check("t6_dat", datrd, 32'hC0DE_0000);
    tick(); idle(); #1;
    check("t6_idle_err", err, 0);
    check("t6_sticky", sticky, 0);
    // reset in the middle of an active transfer
    tick(); req(32'h3000_0060, 0);
    tick(); #1;
    check("t7_stb", s_stb, 6'b100000);
    tick(); rst = 1; #1;
    check("t7_stb_hold", s_stb, 6'b100000);
    tick(); rst = 0; idle(); #1;
    check("t7_stb", s_stb, 0);
    check("t7_cyc", s_cyc, 0);
    check("t7_ack", ack, 0);
    check("t7_datrd", datrd, 0);
    check("t7_cause", cause, 0);
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
